// File: rtl/bure_stage_if_prefetch.sv
// bure_stage_if_prefetch: instruction-fetch stage with a prefetch FIFO.
// Keeps up to MAX_OUTSTANDING sequential reads in flight, buffers the
// returned instructions with their PCs, and hands them to decode over a
// valid/ready handshake. A redirect flushes the buffer and drops the
// responses that are still owed by the memory.
// Optional build macro: BURE_IF_BYPASS_EN -- when defined, a response that
// arrives while the buffer is empty is forwarded to decode in the same cycle.
module bure_stage_if_prefetch #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    INSTR_WIDTH     = 32,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic                   o_imem_raddr_valid,
    input  logic                   i_imem_raddr_ready,
    output logic [ADDR_WIDTH-1:0]  o_imem_raddr,
    input  logic                   i_imem_rdata_valid,
    output logic                   o_imem_rdata_ready,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic                   o_instr_valid,
    input  logic                   i_instr_ready,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_instr_pc
);

    localparam int STEP = INSTR_WIDTH / 8;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int QW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // Fetch state and occupancy counters
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count, inflight, drop_cnt;
    logic [CW:0]            credit_used;

    // Prefetch buffer storage
    logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_pc    [FIFO_DEPTH];

    // PCs of requests still owed by memory, in issue order
    logic [ADDR_WIDTH-1:0]  pcq [MAX_OUTSTANDING];
    logic [QW-1:0]          pcq_wr, pcq_rd;
    logic [QW-1:0]          pcq_wr_nxt, pcq_rd_nxt;

    logic issue_fire, rsp, rsp_keep, fifo_nempty, byp, push, pop;
    logic [ADDR_WIDTH-1:0] rsp_pc;

    // Credits count both buffered entries and responses still on their way,
    // so every response is guaranteed a slot and rdata_ready can stay high.
    assign credit_used        = {1'b0, inflight} + {1'b0, count};
    assign o_imem_raddr_valid = !i_rst && !i_redirect
                                && (inflight < CW'(MAX_OUTSTANDING))
                                && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign o_imem_raddr       = fetch_pc;
    assign o_imem_rdata_ready = 1'b1;
    assign issue_fire         = o_imem_raddr_valid && i_imem_raddr_ready;

    assign rsp         = i_imem_rdata_valid && !i_rst;
    assign rsp_pc      = pcq[pcq_rd];
    assign rsp_keep    = rsp && !i_redirect && (drop_cnt == '0);
    assign fifo_nempty = (count != '0);

`ifdef BURE_IF_BYPASS_EN
    assign byp = rsp_keep && !fifo_nempty;
`else
    assign byp = 1'b0;
`endif

    // Outputs are forced to zero whenever nothing valid is presented
    assign o_instr_valid = !i_rst && !i_redirect && (fifo_nempty || byp);
    assign o_instr       = !o_instr_valid ? '0 : (byp ? i_imem_rdata : fifo_instr[rd_ptr]);
    assign o_instr_pc    = !o_instr_valid ? '0 : (byp ? rsp_pc : fifo_pc[rd_ptr]);

    assign pop  = fifo_nempty && o_instr_valid && i_instr_ready;
    assign push = rsp_keep && !(byp && i_instr_ready);

    assign pcq_wr_nxt = (pcq_wr == QW'(MAX_OUTSTANDING - 1)) ? '0 : pcq_wr + QW'(1);
    assign pcq_rd_nxt = (pcq_rd == QW'(MAX_OUTSTANDING - 1)) ? '0 : pcq_rd + QW'(1);

    // Control state: fetch PC, pointers, inflight/drop accounting, redirect flush
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
        end else begin
            inflight <= inflight + CW'(issue_fire) - CW'(rsp);
            if (issue_fire) pcq_wr <= pcq_wr_nxt;
            // The PC queue pops on every response, dropped or not
            if (rsp)        pcq_rd <= pcq_rd_nxt;
            if (i_redirect) begin
                fetch_pc <= i_redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                // A response landing in the redirect cycle is already dropped
                drop_cnt <= inflight - CW'(rsp);
            end else begin
                if (issue_fire)                 fetch_pc <= fetch_pc + ADDR_WIDTH'(STEP);
                if (rsp && (drop_cnt != '0))    drop_cnt <= drop_cnt - CW'(1);
                if (push)                       wr_ptr   <= wr_ptr + PW'(1);
                if (pop)                        rd_ptr   <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage writes; contents are don't-care until covered by the pointers
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= i_imem_rdata;
            fifo_pc[wr_ptr]    <= rsp_pc;
        end
        if (issue_fire) pcq[pcq_wr] <= fetch_pc;
    end

endmodule

// File: tb/tb_bure_stage_if_prefetch.sv
// Directed bench for bure_stage_if_prefetch (default build, MAX_OUTSTANDING=2,
// FIFO_DEPTH=4). Memory model returns addr ^ KEY with 1-cycle latency unless
// held; held responses queue up and are returned one per cycle on release.
module tb_bure_stage_if_prefetch;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        raddr_valid, raddr_ready;
    logic [31:0] raddr;
    logic        rdata_valid, rdata_ready;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] memq [$];
    logic        mem_hold = 1'b1;

    bure_stage_if_prefetch #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(4),
        .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_raddr_valid(raddr_valid), .i_imem_raddr_ready(raddr_ready),
        .o_imem_raddr(raddr),
        .i_imem_rdata_valid(rdata_valid), .o_imem_rdata_ready(rdata_ready),
        .i_imem_rdata(rdata),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_instr_valid(instr_valid), .i_instr_ready(instr_ready),
        .o_instr(instr), .o_instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    // Record fired requests (inputs are stable around negedge)
    always @(negedge clk) begin
        if (!rst && raddr_valid && raddr_ready) memq.push_back(raddr);
    end

    // Return responses in order, after the tasks' own input updates
    always @(posedge clk) begin
        #2;
        if (!mem_hold && memq.size() > 0) begin
            rdata_valid = 1'b1;
            rdata       = memq.pop_front() ^ KEY;
        end else begin
            rdata_valid = 1'b0;
            rdata       = '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        mem_hold = 1'b1;
        step();
        memq.delete();
        step();
        rst      = 1'b0;
        mem_hold = 1'b0;
    endtask

    // Wait up to 20 cycles for an instruction; counts as a comparison
    task automatic wait_instr(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: timeout waiting for o_instr_valid", name);
        end
    endtask

    task automatic check_head(input string name, input logic [31:0] exp_pc);
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== (exp_pc ^ KEY)) begin
            n_fail++;
            $display("FAIL %s: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                     name, instr_valid, instr_pc, instr, exp_pc, exp_pc ^ KEY);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        raddr_ready = 1'b1; instr_ready = 1'b1; mem_hold = 1'b1;
        step(); step();
        @(negedge clk);
        n_checks++;
        if (raddr_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            instr_pc !== 32'h0 || rdata_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: got raddr_valid=%b instr_valid=%b instr=%h pc=%h rdata_ready=%b, expected 0 0 0 0 1",
                     raddr_valid, instr_valid, instr, instr_pc, rdata_ready);
        end
        redirect = 1'b0;
        // Fetch must start at RESET_PC on release
        do_reset();
        @(negedge clk);
        n_checks++;
        if (raddr_valid !== 1'b1 || raddr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req: got valid=%b addr=%h, expected 1 00000000", raddr_valid, raddr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc = 32'h0;
        int delivered = 0;
        int gaps = 0;
        raddr_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                check_head("stream_seq", exp_pc);
                exp_pc += 32'h4;
                delivered++;
            end else if (delivered > 0) begin
                gaps++;
            end
        end
        n_checks++;
        if (gaps != 0 || delivered < 14) begin
            n_fail++;
            $display("FAIL stream_throughput: got delivered=%0d gaps=%0d, expected >=14 and 0", delivered, gaps);
        end
    endtask

    task automatic test_backpressure();
        int fires = 0;
        raddr_ready = 1'b1; instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (raddr_valid && raddr_ready) fires++;
        end
        n_checks++;
        if (fires != 4 || raddr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_fill: got fires=%0d raddr_valid=%b, expected 4 and 0", fires, raddr_valid);
        end
        step();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_head("bp_drain", 32'(4 * i));
        end
    endtask

    task automatic test_addr_stall();
        raddr_ready = 1'b0; instr_ready = 1'b1;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h10;
        @(negedge clk);
        n_checks++;
        if (raddr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_redirect_withdraw: got raddr_valid=%b, expected 0", raddr_valid);
        end
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (raddr_valid !== 1'b1 || raddr !== 32'h10) begin
                n_fail++;
                $display("FAIL stall_hold: got valid=%b addr=%h, expected 1 00000010", raddr_valid, raddr);
            end
            step();
        end
        raddr_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (raddr_valid !== 1'b1 || raddr !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_fire: got valid=%b addr=%h, expected 1 00000010", raddr_valid, raddr);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (raddr !== 32'h14) begin
            n_fail++;
            $display("FAIL stall_advance: got addr=%h, expected 00000014", raddr);
        end
        wait_instr("stall_first");
        check_head("stall_first_pc", 32'h10);
    endtask

    task automatic test_redirect();
        raddr_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        mem_hold = 1'b1;
        step(); step();
        @(negedge clk);
        n_checks++;
        if (raddr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_two_inflight: got raddr_valid=%b, expected 0", raddr_valid);
        end
        step();
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_cycle_valid: got %b, expected 0", instr_valid);
        end
        step();
        redirect = 1'b0; mem_hold = 1'b0;
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_after_empty: got %b, expected 0", instr_valid);
        end
        wait_instr("redir_first");
        check_head("redir_first_pc", 32'h100);
        @(negedge clk);
        check_head("redir_second_pc", 32'h104);
    endtask

    task automatic test_redirect_rsp();
        raddr_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        mem_hold = 1'b1;
        step(); step(); step();
        // Response for 0x0 arrives in this redirect cycle
        mem_hold = 1'b0; redirect = 1'b1; redirect_pc = 32'h180;
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_first_redirect: got valid=%b, expected 0", instr_valid);
        end
        step();
        redirect_pc = 32'h200;
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0 || raddr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_second_redirect: got instr_valid=%b raddr_valid=%b, expected 0 0",
                     instr_valid, raddr_valid);
        end
        step();
        redirect = 1'b0;
        wait_instr("rr_first");
        check_head("rr_first_pc", 32'h200);
        @(negedge clk);
        check_head("rr_second_pc", 32'h204);
    endtask

    task automatic test_reset_mid();
        raddr_ready = 1'b1; instr_ready = 1'b0;
        do_reset();
        step(); step(); step();
        // Two entries buffered, one request (0x8) still in flight
        rst = 1'b1; mem_hold = 1'b1;
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || raddr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got instr_valid=%b instr=%h pc=%h raddr_valid=%b, expected 0 0 0 0",
                     instr_valid, instr, instr_pc, raddr_valid);
        end
        step();
        memq.delete();
        rst = 1'b0; mem_hold = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (raddr_valid !== 1'b1 || raddr !== 32'h0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_restart: got raddr_valid=%b addr=%h instr_valid=%b, expected 1 00000000 0",
                     raddr_valid, raddr, instr_valid);
        end
        wait_instr("midrst_first");
        check_head("midrst_first_pc", 32'h0);
        @(negedge clk);
        check_head("midrst_second_pc", 32'h4);
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        raddr_ready = 1'b1; instr_ready = 1'b1;
        rdata_valid = 1'b0; rdata = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_addr_stall();
        test_redirect();
        test_redirect_rsp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
